sram_access_controller: RTL and testbench
=========================================

Name: sram_access_controller

Overview:
- Multi-cycle controller between the EXE→MEM pipeline boundary and an external 16-bit asynchronous SRAM.
- Converts one 32-bit load/store from the pipeline into two sequenced halfword SRAM accesses.
- Asserts freeze to the pipeline stage registers until the access completes.
- Returns the assembled 32-bit read word to the memory stage register's data path.

Parameters:
- ADDR_W, 18, SRAM halfword address width.
- WAIT_CYCLES, 1, extra cycles each halfword access is held; each half lasts WAIT_CYCLES+1 cycles; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- memoryReadEnabled  input  1  load request from EXE stage.
- memoryWriteEnabled  input  1  store request from EXE stage.
- address  input  32  byte address; bits [1:0] ignored (word-aligned).
- writeData  input  32  store data.
- readData  output  32  loaded word; valid while ready=1 after a read.
- ready  output  1  access complete / no access pending.
- freeze  output  1  stall all pipeline stage registers.
- sram_addr  output  ADDR_W  SRAM halfword address.
- sram_dq_out  output  16  SRAM write data.
- sram_dq_in  input  16  SRAM read data.
- sram_dq_oe  output  1  1 = controller drives the SRAM data bus.
- sram_we_n  output  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - State → IDLE; wait counter → 0.
  - readData=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - Latched address and data registers → 0.
  - Reset mid-access aborts immediately; no further SRAM strobes.
- req = memoryReadEnabled | memoryWriteEnabled.
- If both read and write are asserted, the access is a write; read is ignored and readData is unchanged.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~req; freeze = req (combinational).
  - On req, latch the word address address[ADDR_W:2], writeData and the write flag; next state LOW; counter=0.
- LOW:
  - sram_addr = {word,1'b0}; for a write, sram_dq_out = data[15:0], sram_dq_oe=1, sram_we_n=0.
  - The counter increments each cycle.
  - When counter==WAIT_CYCLES: a read samples sram_dq_in into readData[15:0]; counter clears; next state HIGH.
- HIGH:
  - sram_addr = {word,1'b1}; data[31:16] for a write.
  - On the last cycle a read samples sram_dq_in into readData[31:16]; next state DONE.
- DONE:
  - ready=1, freeze=0 for exactly one cycle; sram_we_n=1, sram_dq_oe=0.
  - Next state IDLE unconditionally; the pipeline advances on this edge.
  - The request seen in the following IDLE cycle is a new instruction.
- freeze = ~ready in all states. LOW and HIGH always drive ready=0.
- Latency: request first seen in IDLE at cycle t → DONE at cycle t + 2·(WAIT_CYCLES+1) + 1 (t+5 at default).
- Between the two halves, sram_we_n returns high for zero cycles. The address change and we_n are registered together, and the SRAM is write-through.
- A write leaves readData unchanged.
- Inputs are ignored outside IDLE: the frozen pipeline holds them stable, and the latched copies are used.
- Address wrap: only address[ADDR_W:2] is used; higher bits are discarded silently.

Test Plan:
- Reset asserted mid-HIGH of a write → same-cycle sram_we_n=1, sram_dq_oe=0, readData=0. After release with no request: ready=1, freeze=0.
- Write: address=0x0000_0010, writeData=0xDEAD_BEEF, WAIT_CYCLES=1.
  - sram_addr=0x8 with dq=0xBEEF and we_n=0 for 2 cycles.
  - Then sram_addr=0x9 with dq=0xDEAD for 2 cycles.
  - ready=1 at cycle t+5; freeze=1 during t..t+4.
- Read back the same address with an SRAM model → readData=0xDEAD_BEEF at the DONE cycle; sram_we_n stays 1 throughout.
- Read and write asserted together, writeData=0x1234_5678 → write performed; readData keeps its previous value.
- WAIT_CYCLES=0, back-to-back loads held across DONE → each access takes 3 cycles, followed by a new IDLE request. ready pulses exactly once per access.
- No request for 10 cycles → ready=1, freeze=0, sram_we_n=1, sram_dq_oe=0 constantly.

Source files
------------

// File: rtl/sram_access_controller_if.sv
// Pipeline-side and SRAM-side signal bundle for the SRAM access controller.
// The controller takes the slave view; the pipeline/SRAM environment takes the master view.
interface sram_access_controller_if #(
   parameter int ADDR_W = 18
);
   logic              memoryReadEnabled;
   logic              memoryWriteEnabled;
   logic [31:0]       address;
   logic [31:0]       writeData;
   logic [31:0]       readData;
   logic              ready;
   logic              freeze;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_out;
   logic [15:0]       sram_dq_in;
   logic              sram_dq_oe;
   logic              sram_we_n;

   modport slave (
      input  memoryReadEnabled, memoryWriteEnabled, address, writeData, sram_dq_in,
      output readData, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport master (
      output memoryReadEnabled, memoryWriteEnabled, address, writeData, sram_dq_in,
      input  readData, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_access_controller.sv
// Splits one 32-bit pipeline load/store into two halfword accesses to a 16-bit async SRAM,
// freezing the pipeline until the word completes.
//
// state | meaning
// IDLE  | no access in flight; ready follows ~req
// LOW   | halfword 0 on the bus ({word,0}), held WAIT_CYCLES+1 cycles
// HIGH  | halfword 1 on the bus ({word,1}), held WAIT_CYCLES+1 cycles
// DONE  | one-cycle ready pulse; pipeline advances on this edge
module sram_access_controller #(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input logic                    clk,
   input logic                    rst,
   sram_access_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] WAIT_TC = 4'(WAIT_CYCLES);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic [ADDR_W-2:0] word_q;
   logic [31:0]       data_q;
   logic              wr_q;

   logic              req;
   logic              last;
   logic              latch;
   logic [ADDR_W-2:0] word_nxt;
   logic [31:0]       data_nxt;
   logic              wr_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [15:0]       dq_nxt;
   logic              oe_nxt;
   logic              we_n_nxt;
   logic              addr_unused;

   assign req         = bus.memoryReadEnabled | bus.memoryWriteEnabled;
   assign last        = (cnt == WAIT_TC);
   assign latch       = (state == IDLE) && req;
   assign addr_unused = ^{bus.address[31:ADDR_W+1], bus.address[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req)  state_nxt = LOW;
         LOW:     if (last) state_nxt = HIGH;
         HIGH:    if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // SRAM strobes are registered from the next state so address, data and we_n move together
   always_comb begin
      bus.ready  = (state == IDLE) ? ~req : (state == DONE);
      bus.freeze = ~bus.ready;
      word_nxt   = latch ? bus.address[ADDR_W:2] : word_q;
      data_nxt   = latch ? bus.writeData : data_q;
      wr_nxt     = latch ? bus.memoryWriteEnabled : wr_q;
      addr_nxt   = bus.sram_addr;
      dq_nxt     = bus.sram_dq_out;
      oe_nxt     = 1'b0;
      we_n_nxt   = 1'b1;
      if (state_nxt == LOW) begin
         addr_nxt = {word_nxt, 1'b0};
         if (wr_nxt) begin
            dq_nxt   = data_nxt[15:0];
            oe_nxt   = 1'b1;
            we_n_nxt = 1'b0;
         end
      end else if (state_nxt == HIGH) begin
         addr_nxt = {word_nxt, 1'b1};
         if (wr_nxt) begin
            dq_nxt   = data_nxt[31:16];
            oe_nxt   = 1'b1;
            we_n_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt             <= '0;
         word_q          <= '0;
         data_q          <= '0;
         wr_q            <= 1'b0;
         bus.readData    <= '0;
         bus.sram_addr   <= '0;
         bus.sram_dq_out <= '0;
         bus.sram_dq_oe  <= 1'b0;
         bus.sram_we_n   <= 1'b1;
      end else begin
         word_q          <= word_nxt;
         data_q          <= data_nxt;
         wr_q            <= wr_nxt;
         bus.sram_addr   <= addr_nxt;
         bus.sram_dq_out <= dq_nxt;
         bus.sram_dq_oe  <= oe_nxt;
         bus.sram_we_n   <= we_n_nxt;
         if ((state == LOW) || (state == HIGH)) cnt <= last ? 4'd0 : cnt + 4'd1;
         else                                   cnt <= 4'd0;
         if ((state == LOW) && last && !wr_q)  bus.readData[15:0]  <= bus.sram_dq_in;
         if ((state == HIGH) && last && !wr_q) bus.readData[31:16] <= bus.sram_dq_in;
      end
   end
endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench: two controllers (WAIT_CYCLES=1 and 0), each with a small behavioural SRAM.
module tb_sram_access_controller;
   localparam int ADDR_W = 18;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sram_access_controller_if #(.ADDR_W(ADDR_W)) if1 ();
   sram_access_controller_if #(.ADDR_W(ADDR_W)) if0 ();

   sram_access_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   sram_access_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

   logic [15:0] mem1 [0:255];
   logic [15:0] mem0 [0:255];

   always @(posedge clk) if (!if1.sram_we_n && if1.sram_dq_oe) mem1[if1.sram_addr[7:0]] <= if1.sram_dq_out;
   always @(posedge clk) if (!if0.sram_we_n && if0.sram_dq_oe) mem0[if0.sram_addr[7:0]] <= if0.sram_dq_out;
   assign if1.sram_dq_in = mem1[if1.sram_addr[7:0]];
   assign if0.sram_dq_in = mem0[if0.sram_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      if1.memoryReadEnabled  = rd;
      if1.memoryWriteEnabled = wr;
      if1.address            = a;
      if1.writeData          = d;
   endtask

   // Full word access on dut1; start at a negedge, returns at the DONE negedge with inputs idle.
   task automatic access1(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [ADDR_W-1:0] sa, input logic [31:0] rd_exp);
      drive1(rd, wr, a, d);
      #1;
      check({tag, " t ready"}, 32'(if1.ready), 32'd0);
      check({tag, " t freeze"}, 32'(if1.freeze), 32'd1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check({tag, " addr"}, 32'(if1.sram_addr), 32'(sa + ((c > 2) ? 1 : 0)));
         check({tag, " freeze"}, 32'(if1.freeze), 32'd1);
         check({tag, " we_n"}, 32'(if1.sram_we_n), wr ? 32'd0 : 32'd1);
         check({tag, " oe"}, 32'(if1.sram_dq_oe), wr ? 32'd1 : 32'd0);
         if (wr) check({tag, " dq"}, 32'(if1.sram_dq_out), (c > 2) ? 32'(d[31:16]) : 32'(d[15:0]));
      end
      @(negedge clk);
      check({tag, " done ready"}, 32'(if1.ready), 32'd1);
      check({tag, " done freeze"}, 32'(if1.freeze), 32'd0);
      check({tag, " done we_n"}, 32'(if1.sram_we_n), 32'd1);
      check({tag, " done oe"}, 32'(if1.sram_dq_oe), 32'd0);
      check({tag, " readData"}, if1.readData, rd_exp);
      drive1(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 16'h0;
         mem0[i] = 16'h0;
      end
      mem0[2] = 16'h1111; mem0[3] = 16'h2222;
      mem0[4] = 16'h3333; mem0[5] = 16'h4444;
      drive1(1'b0, 1'b0, 32'h0, 32'h0);
      if0.memoryReadEnabled = 1'b0; if0.memoryWriteEnabled = 1'b0;
      if0.address = 32'h0; if0.writeData = 32'h0;

      repeat (2) @(negedge clk);
      check("rst readData", if1.readData, 32'h0);
      check("rst sram_addr", 32'(if1.sram_addr), 32'h0);
      check("rst we_n", 32'(if1.sram_we_n), 32'd1);
      check("rst oe", 32'(if1.sram_dq_oe), 32'd0);
      check("rst dq_out", 32'(if1.sram_dq_out), 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle ready", 32'(if1.ready), 32'd1);
         check("idle freeze", 32'(if1.freeze), 32'd0);
         check("idle we_n", 32'(if1.sram_we_n), 32'd1);
         check("idle oe", 32'(if1.sram_dq_oe), 32'd0);
      end

      access1("wr", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 18'h8, 32'h0);
      check("mem lo", 32'(mem1[8]), 32'h0000_BEEF);
      check("mem hi", 32'(mem1[9]), 32'h0000_DEAD);

      @(negedge clk);
      access1("rd", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 18'h8, 32'hDEAD_BEEF);

      @(negedge clk);
      access1("rdwr", 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 18'h10, 32'hDEAD_BEEF);
      check("rdwr mem lo", 32'(mem1[16]), 32'h0000_5678);
      check("rdwr mem hi", 32'(mem1[17]), 32'h0000_1234);

      @(negedge clk);
      access1("wrap", 1'b1, 1'b0, 32'hFFF0_0010, 32'h0, 18'h8, 32'hDEAD_BEEF);

      // Reset in the middle of the high half of a write
      @(negedge clk);
      drive1(1'b0, 1'b1, 32'h0000_0030, 32'hAAAA_5555);
      repeat (3) @(negedge clk);
      check("pre-rst we_n", 32'(if1.sram_we_n), 32'd0);
      check("pre-rst addr", 32'(if1.sram_addr), 32'h19);
      #1 rst = 1'b0;
      #1;
      check("mid rst we_n", 32'(if1.sram_we_n), 32'd1);
      check("mid rst oe", 32'(if1.sram_dq_oe), 32'd0);
      check("mid rst readData", if1.readData, 32'h0);
      drive1(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post rst ready", 32'(if1.ready), 32'd1);
         check("post rst freeze", 32'(if1.freeze), 32'd0);
      end
      check("aborted hi", 32'(mem1[25]), 32'h0);
      check("aborted lo", 32'(mem1[24]), 32'h0000_5555);

      // WAIT_CYCLES=0: two loads held back-to-back across DONE
      if0.memoryReadEnabled = 1'b1;
      if0.address = 32'h0000_0004;
      for (int c = 0; c < 8; c++) begin
         #1;
         check("b2b ready", 32'(if0.ready), (c == 3 || c == 7) ? 32'd1 : 32'd0);
         check("b2b we_n", 32'(if0.sram_we_n), 32'd1);
         if (c == 3) begin
            check("b2b rd0", if0.readData, 32'h2222_1111);
            if0.address = 32'h0000_0008;
         end
         if (c == 7) begin
            check("b2b rd1", if0.readData, 32'h4444_3333);
            if0.memoryReadEnabled = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b idle ready", 32'(if0.ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
